demux_8x1_deser: RTL and testbench
==================================

Name: demux_8x1_deser

Overview:
- Serial-to-parallel collector. It is the receive-side counterpart of the 8:1 mux serializer, which drives the mux select from a counter to emit one bit per cycle.
- A 3-bit slot pointer acts as a 1:8 demux select. Each accepted serial bit is steered into one bit slot of an 8-bit shadow register.
- After 8 accepted bits the completed byte is presented with a one-cycle valid pulse.
- Sits directly after the serializer path and feeds byte-wide logic downstream.

Parameters:
- LSB_FIRST, 1: 1 means the first accepted bit lands in bit 0; 0 means the first accepted bit lands in bit 7.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is accepted on this rising edge.
- clear  input  1  synchronous abort; discards any partial byte.
- dout  output  8  last completed byte; held stable between completions.
- dout_valid  output  1  one-cycle pulse when dout updates.
- sel  output  3  current slot pointer, i.e. the demux select (count of bits accepted in the current byte).
- busy  output  1  high while a partial byte is held.

Behaviour:
- Reset: rst_n low forces, asynchronously, sel=0, shadow=8'h00, dout=8'h00, dout_valid=0, busy=0, state=IDLE. This applies at any point, including mid-byte; the partial byte is lost.
- States:
  - IDLE: sel==0, no partial byte.
  - COLLECT: 1..7 bits held.
- Slot index written = sel when LSB_FIRST=1; 7-sel when LSB_FIRST=0.
- IDLE + din_valid: write din to its slot, sel<=1, go to COLLECT.
- COLLECT + din_valid with sel<7: write slot, sel<=sel+1.
- COLLECT + din_valid with sel==7 (8th bit):
  - dout <= shadow with the incoming bit merged.
  - dout_valid<=1 for exactly one cycle.
  - sel wraps to 0; go to IDLE.
  - Shadow need not be cleared, because every slot is rewritten before the next completion.
- din_valid low: sel, shadow and state hold. Gaps of any length are allowed.
- Latency: dout/dout_valid are registered and appear on the cycle after the edge that accepts the 8th bit.
- Back-to-back bytes: din_valid may stay high continuously, giving one completed byte every 8 cycles. The dout_valid pulse for byte n coincides with acceptance of bit 0 of byte n+1.
- clear (synchronous):
  - sel<=0, state<=IDLE; din on that cycle is ignored.
  - clear beats din_valid, including on the 8th bit: no completion and no dout_valid.
  - dout keeps its previous value.
- busy = (state==COLLECT); it is combinational from the state register.
- dout_valid is never high on two consecutive cycles.

Decomposition:
- Shared package holds:
  - DATA_W=8 and SEL_W=3 constants.
  - State enum: IDLE, COLLECT.
  - A SEL_LAST=3'd7 constant.
- One natural sub-module: demux_1x8. It is combinational and produces a one-hot 8-bit write enable from sel and an enable input. It mirrors mux_8x1_2 structurally: two 1:4 stages selected by sel[1:0], gated by sel[2].
- The top level holds the counter, FSM, shadow and output registers.

Test Plan:
- Reset mid-byte: accept 3 bits, pull rst_n low between edges. Outputs must go to 0 immediately without waiting for an edge, and sel must read 0. After release, a full byte 0x5A yields dout=0x5A.
- Contiguous, LSB_FIRST=1: stream 1,0,1,0,0,1,0,1 with din_valid high for 8 cycles. dout=0xA5 and dout_valid=1 on exactly the cycle after the 8th bit. sel must read 0..7 then 0.
- Gapped input: bits of 0x3C with 2 idle cycles between each. Same result, 0x3C. sel and busy hold during gaps, and dout_valid pulses once.
- Back-to-back: 0xFF then 0x00 with din_valid held for 16 cycles. Two pulses exactly 8 cycles apart with dout 0xFF then 0x00. The first pulse coincides with bit 0 of the second byte being accepted.
- Clear:
  - After 5 bits, assert clear together with din_valid, then send 0x81. Only a single pulse occurs, with dout=0x81, and busy drops the cycle after clear.
  - Repeat with clear on the 8th bit: no pulse, and dout is unchanged.
- Round trip: LSB_FIRST=1, with mux_8x1_2 driven by a free-running 3-bit counter on a random byte. Compare dout to the source byte over 256 values.
- MSB-first: LSB_FIRST=0 with the stream 1,0,1,0,0,1,0,1 gives dout=0xA5.

Source files
------------

// File: rtl/demux_8x1_deser_pkg.sv
// Shared definitions for the 8:1 serial-to-parallel collector.
// Holds the data/select widths, the last-slot constant, the collector
// state encoding and the helper that maps the slot pointer onto a bit
// position for either bit order.
package demux_8x1_deser_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] SEL_LAST = 3'd7;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  // With MSB-first order the first accepted bit belongs in bit 7, so the
  // pointer is mirrored instead of used directly.
  function automatic logic [SEL_W-1:0] slotIndex(input logic [SEL_W-1:0] sel,
                                                 input bit lsbFirst);
    return lsbFirst ? sel : (SEL_LAST - sel);
  endfunction

endpackage

// File: rtl/demux_8x1_deser_if.sv
// Byte-collector bus: serial input side plus the parallel byte output.
//   din, din_valid : serial bit and its qualifier
//   clear          : synchronous abort of a partial byte
//   dout           : last completed byte
//   dout_valid     : one-cycle pulse when dout updates
//   sel            : current slot pointer (bits held in the current byte)
//   busy           : a partial byte is held
// master = the producer/consumer around the collector, slave = the collector.
interface demux_8x1_deser_if
  import demux_8x1_deser_pkg::*;
();

  logic              din;
  logic              din_valid;
  logic              clear;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [SEL_W-1:0]  sel;
  logic              busy;

  modport master (
    output din, din_valid, clear,
    input  dout, dout_valid, sel, busy
  );

  modport slave (
    input  din, din_valid, clear,
    output dout, dout_valid, sel, busy
  );

endinterface

// File: rtl/demux_8x1_deser_demux_1x8.sv
// Combinational 1:8 demux producing a one-hot write enable.
//   i_sel : slot to enable
//   i_en  : global enable; all outputs low when it is low
//   o_we  : one-hot (or all-zero) write-enable vector
// Built as two 1:4 stages decoded by i_sel[1:0], with i_sel[2] choosing
// which stage receives the enable.
module demux_1x8
  import demux_8x1_deser_pkg::*;
(
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_en,
  output logic [DATA_W-1:0] o_we
);

  logic       w_lowEn;
  logic       w_highEn;
  logic [3:0] w_lowWe;
  logic [3:0] w_highWe;

  assign w_lowEn  = i_en & ~i_sel[2];
  assign w_highEn = i_en &  i_sel[2];

  always_comb begin
    w_lowWe  = 4'b0000;
    w_highWe = 4'b0000;
    w_lowWe[i_sel[1:0]]  = w_lowEn;
    w_highWe[i_sel[1:0]] = w_highEn;
  end

  assign o_we = {w_highWe, w_lowWe};

endmodule

// File: rtl/demux_8x1_deser.sv
// Serial-to-parallel collector (receive side of the 8:1 serializer).
// Each accepted serial bit is steered by the slot pointer into an 8-bit
// shadow register; the eighth bit completes the byte, which is presented
// on dout together with a one-cycle dout_valid pulse.
//   i_clk    : system clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   bus      : collector bus (slave side), see demux_8x1_deser_if
// Parameter LSB_FIRST: 1 = first bit lands in bit 0, 0 = first bit in bit 7.
module demux_8x1_deser
  import demux_8x1_deser_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  demux_8x1_deser_if.slave bus
);

  state_t            r_state;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_shadow;
  logic [DATA_W-1:0] r_dout;
  logic              r_doutValid;

  logic              w_accept;
  logic [SEL_W-1:0]  w_slot;
  logic [DATA_W-1:0] w_writeEn;
  logic [DATA_W-1:0] w_merged;

  // clear wins over din_valid, so a cleared cycle never writes the shadow.
  assign w_accept = bus.din_valid & ~bus.clear;
  assign w_slot   = slotIndex(r_sel, LSB_FIRST);

  demux_1x8 u_demux (
    .i_sel (w_slot),
    .i_en  (w_accept),
    .o_we  (w_writeEn)
  );

  // Shadow with the incoming bit already merged; on the eighth bit this is
  // the completed byte, so it can go straight to dout.
  assign w_merged = (r_shadow & ~w_writeEn) | ({DATA_W{bus.din}} & w_writeEn);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_shadow    <= '0;
      r_dout      <= '0;
      r_doutValid <= 1'b0;
    end else begin
      r_doutValid <= 1'b0;
      if (bus.clear) begin
        r_state <= IDLE;
        r_sel   <= '0;
      end else if (bus.din_valid) begin
        r_shadow <= w_merged;
        case (r_state)
          IDLE: begin
            r_sel   <= 3'd1;
            r_state <= COLLECT;
          end
          COLLECT: begin
            if (r_sel == SEL_LAST) begin
              // Shadow is not cleared: every slot is rewritten before the
              // next completion.
              r_dout      <= w_merged;
              r_doutValid <= 1'b1;
              r_sel       <= '0;
              r_state     <= IDLE;
            end else begin
              r_sel <= r_sel + 3'd1;
            end
          end
          default: begin
            r_sel   <= '0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_doutValid;
  assign bus.sel        = r_sel;
  assign bus.busy       = (r_state == COLLECT);

endmodule

// File: tb/tb_demux_8x1_deser.sv
// Bench for demux_8x1_deser: one LSB-first and one MSB-first instance fed
// with the same serial stream; completed bytes are checked against queues
// of expected values, plus directed checks of sel/busy/dout_valid.
module tb_demux_8x1_deser;
  import demux_8x1_deser_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  demux_8x1_deser_if busL ();
  demux_8x1_deser_if busM ();

  demux_8x1_deser #(.LSB_FIRST(1'b1)) dutL (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (busL)
  );

  demux_8x1_deser #(.LSB_FIRST(1'b0)) dutM (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (busM)
  );

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  logic [7:0] expQL[$];
  logic [7:0] expQM[$];
  int         pulseCycles[$];
  logic       prevVL = 1'b0;
  logic       prevVM = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // Completed-byte monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busL.dout_valid) begin
        pulseCycles.push_back(cycle);
        checkOutput("noDoubleL", {7'd0, prevVL}, 8'd0);
        if (expQL.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedL: got pulse dout=%0h want none", busL.dout);
        end else begin
          checkOutput("scoreL", busL.dout, expQL.pop_front());
        end
      end
      if (busM.dout_valid) begin
        checkOutput("noDoubleM", {7'd0, prevVM}, 8'd0);
        if (expQM.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedM: got pulse dout=%0h want none", busM.dout);
        end else begin
          checkOutput("scoreM", busM.dout, expQM.pop_front());
        end
      end
    end
    prevVL <= busL.dout_valid;
    prevVM <= busM.dout_valid;
  end

  // Drives both instances for one cycle; returns 1 ns after the edge.
  task automatic applyStimulus(input logic d, input logic v, input logic c);
    busL.din = d; busL.din_valid = v; busL.clear = c;
    busM.din = d; busM.din_valid = v; busM.clear = c;
    @(posedge clk);
    #1;
  endtask

  // stream[i] is the i-th bit sent; a byte is assumed to start at sel=0.
  task automatic sendBits(input logic [7:0] stream, input logic [7:0] expL,
                          input logic [7:0] expM, input int gap);
    expQL.push_back(expL);
    expQM.push_back(expM);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(stream[i], 1'b1, 1'b0);
      if (i < 7) begin
        checkOutput("sel", {5'd0, busL.sel}, 8'(i + 1));
        checkOutput("busy", {7'd0, busL.busy}, 8'd1);
        checkOutput("dvLow", {7'd0, busL.dout_valid}, 8'd0);
        for (int g = 0; g < gap; g++) begin
          applyStimulus(1'b0, 1'b0, 1'b0);
          checkOutput("gapSel", {5'd0, busL.sel}, 8'(i + 1));
          checkOutput("gapBusy", {7'd0, busL.busy}, 8'd1);
          checkOutput("gapDv", {7'd0, busL.dout_valid}, 8'd0);
        end
      end else begin
        checkOutput("selWrap", {5'd0, busL.sel}, 8'd0);
        checkOutput("busyEnd", {7'd0, busL.busy}, 8'd0);
        checkOutput("dvHigh", {7'd0, busL.dout_valid}, 8'd1);
        checkOutput("doutL", busL.dout, expL);
        checkOutput("doutM", busM.dout, expM);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] cnt;
    logic [7:0] vb;
    int         n;

    busL.din = 1'b0; busL.din_valid = 1'b0; busL.clear = 1'b0;
    busM.din = 1'b0; busM.din_valid = 1'b0; busM.clear = 1'b0;

    // Reset state
    #12;
    checkOutput("rstSel", {5'd0, busL.sel}, 8'd0);
    checkOutput("rstBusy", {7'd0, busL.busy}, 8'd0);
    checkOutput("rstDout", busL.dout, 8'h00);
    checkOutput("rstDv", {7'd0, busL.dout_valid}, 8'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contiguous 1,0,1,0,0,1,0,1 -> A5 for both bit orders
    sendBits(8'b1010_0101, 8'hA5, 8'hA5, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("dvOneCycle", {7'd0, busL.dout_valid}, 8'd0);
    checkOutput("doutHold", busL.dout, 8'hA5);

    // Asynchronous reset mid-byte
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    busL.din_valid = 1'b0; busM.din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arstSel", {5'd0, busL.sel}, 8'd0);
    checkOutput("arstBusy", {7'd0, busL.busy}, 8'd0);
    checkOutput("arstDoutL", busL.dout, 8'h00);
    checkOutput("arstDoutM", busM.dout, 8'h00);
    checkOutput("arstDv", {7'd0, busL.dout_valid}, 8'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    sendBits(8'h5A, 8'h5A, 8'h5A, 0);

    // Non-palindromic pattern exposes bit order
    sendBits(8'h01, 8'h01, 8'h80, 0);

    // Gapped 3C
    sendBits(8'h3C, 8'h3C, 8'h3C, 2);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Back-to-back FF then 00
    n = pulseCycles.size();
    sendBits(8'hFF, 8'hFF, 8'hFF, 0);
    sendBits(8'h00, 8'h00, 8'h00, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("b2bPulses", 8'(pulseCycles.size() - n), 8'd2);
    if (pulseCycles.size() - n == 2)
      checkOutput("b2bSpacing", 8'(pulseCycles[n+1] - pulseCycles[n]), 8'd8);

    // Clear after 5 bits, together with din_valid
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("clrBusy", {7'd0, busL.busy}, 8'd0);
    checkOutput("clrSel", {5'd0, busL.sel}, 8'd0);
    checkOutput("clrDv", {7'd0, busL.dout_valid}, 8'd0);
    sendBits(8'h81, 8'h81, 8'h81, 0);

    // Clear on the 8th bit: no completion
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("clr8Dv", {7'd0, busL.dout_valid}, 8'd0);
    checkOutput("clr8Busy", {7'd0, busL.busy}, 8'd0);
    checkOutput("clr8Sel", {5'd0, busL.sel}, 8'd0);
    checkOutput("clr8Dout", busL.dout, 8'h81);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("clr8DvNext", {7'd0, busL.dout_valid}, 8'd0);
    checkOutput("clr8DoutNext", busL.dout, 8'h81);

    // Round trip through an 8:1 mux driven by a free-running counter
    cnt = 3'd0;
    for (int v = 0; v < 256; v++) begin
      vb = 8'(v);
      expQL.push_back(vb);
      expQM.push_back(rev(vb));
      for (int k = 0; k < 8; k++) begin
        applyStimulus(vb[cnt], 1'b1, 1'b0);
        cnt = cnt + 3'd1;
      end
    end

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("drainL", 8'(expQL.size()), 8'd0);
    checkOutput("drainM", 8'(expQM.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
